ex_muldiv_divider: RTL and testbench
====================================

# ex_muldiv_divider

Iterative 32-bit integer divider for the EX stage, implementing RISC-V DIV, DIVU, REM and REMU. It consumes the rs1/rs2 operands read in ID and forwarded into EX, computes one quotient bit per cycle, and returns the result with the destination register tag for write-back. The pipeline holds EX while `busy` is high, and uses `flush` on branch mispredict or trap.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort; highest priority.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  input  XLEN  dividend.
- rs2_data  input  XLEN  divisor.
- rd_addr  input  5  destination tag, captured with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion strobe.
- result  output  XLEN  quotient or remainder; holds until the next completion.
- done_rd_addr  output  5  tag of the completed operation; valid with done, then held.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On `start=1` and `flush=0`: latch op, rd_addr, operand signs and |rs1|, |rs2| (signed ops only; unsigned ops take the raw values). Clear the remainder accumulator and iteration counter.
  - Special cases go IDLE->DONE directly; all others go IDLE->CALC.
- Special cases:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_data unchanged.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- CALC: restoring division, one iteration per cycle.
  - Shift the remainder left, bringing in the next dividend bit (MSB first).
  - Trial-subtract the divisor (33-bit subtract). If non-negative, keep the difference and set the quotient bit to 1.
  - 6-bit counter runs 0..31. After the iteration with counter=31, go to DONE.
- Sign fix-up is applied when loading `result` on the CALC->DONE transition:
  - Quotient is negated iff op is DIV and the operand signs differ.
  - Remainder is negated iff op is REM and the dividend is negative. The remainder sign follows the dividend.
  - Unsigned ops are never negated.
- DONE: `done = (state==DONE) && !flush`. Next state is always IDLE. `start` is ignored in DONE.
- `start` is ignored while busy; no queueing.
- flush: any state goes to IDLE on the next edge. No done is produced for the aborted op. If flush and start are high in the same IDLE cycle, flush wins and start is dropped. `result` and `done_rd_addr` are not modified by flush.
- Arithmetic is two's-complement modulo 2^32. |0x80000000| is handled as an unsigned 0x80000000 internally.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, result=0, done_rd_addr=0, all internal registers 0. Reset mid-operation discards the operation. The first start is accepted on the first edge after rst deasserts.
- Let cycle C be the cycle in which start is sampled high in IDLE:
  - busy is high from C+1.
  - Normal ops: CALC spans C+1..C+32; done=1 in C+33; busy drops at C+34. Total latency is 33 cycles.
  - Special cases: done=1 in C+1; busy=1 in C+1 only.
- result and done_rd_addr update on the edge entering DONE, so they are valid in the done cycle and held afterwards.
- Earliest back-to-back start is cycle C+34 (normal) or C+2 (special).
- Flush sampled in cycle F: busy=0 from F+1, and a start is accepted in F+1.

## Test plan
- DIVU 100 / 7, rd=5, start in cycle 0 -> busy=1 in cycles 1..33; done=1 only in cycle 33 with result=14, done_rd_addr=5. REMU on the same operands -> result=2 in cycle 33.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (-2) -> 1.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF with done in cycle 1. REM 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1. REM on the same operands -> 0.
- Start DIVU 100/7 in cycle 0, flush in cycle 10 -> no done; busy=0 in cycle 11. New DIVU 50/5 starting in cycle 11 -> done in cycle 44 with result=10. result and done_rd_addr keep their prior values through cycles 11..43.
- Second start pulses at cycles 5 and 33 while busy -> ignored. Exactly one done (cycle 33); busy=0 in cycle 34. Start at cycle 34 accepted.
- Assert rst asynchronously mid-cycle 20 of an operation -> busy, done, result, done_rd_addr all 0 immediately. No done afterwards. Start after deassert gives normal 33-cycle latency. DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/ex_muldiv_divider_if.sv
// Request/response signals between the EX-stage control and the iterative divider.
interface ex_muldiv_divider_if #(parameter int XLEN = 32);
   logic            start;
   logic            flush;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      done_rd_addr;

   modport master (
      output start, flush, op, rs1_data, rs2_data, rd_addr,
      input  busy, done, result, done_rd_addr
   );

   modport slave (
      input  start, flush, op, rs1_data, rs2_data, rd_addr,
      output busy, done, result, done_rd_addr
   );
endinterface

// File: rtl/ex_muldiv_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module ex_muldiv_divider #(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   ex_muldiv_divider_if.slave   bus
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef struct packed {
      logic       is_rem;
      logic       qneg;
      logic       rneg;
      logic [4:0] rd;
   } ctx_t;

   state_t          state, state_nxt;
   ctx_t            ctx;
   logic [XLEN-1:0] dvd, dvs, rem;
   logic [5:0]      cnt;

   logic            sgn, s1, s2, div0, ovf, special, accept, last, qbit;
   logic [XLEN-1:0] abs1, abs2, spec_res, rem_nxt, quo_nxt, fin;
   logic [XLEN:0]   rem_sh, trial;

   // Operand conditioning in IDLE; unsigned ops take raw values.
   assign sgn      = ~bus.op[0];
   assign s1       = sgn & bus.rs1_data[XLEN-1];
   assign s2       = sgn & bus.rs2_data[XLEN-1];
   assign abs1     = s1 ? -bus.rs1_data : bus.rs1_data;
   assign abs2     = s2 ? -bus.rs2_data : bus.rs2_data;
   assign div0     = (bus.rs2_data == '0);
   assign ovf      = sgn & (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);
   assign special  = div0 | ovf;
   assign spec_res = div0 ? (bus.op[1] ? bus.rs1_data : '1)
                          : (bus.op[1] ? '0 : MIN_NEG);
   assign accept   = (state == IDLE) && bus.start && !bus.flush;

   // The quotient shifts into dvd from the LSB as dividend bits leave the MSB.
   assign rem_sh  = {rem, dvd[XLEN-1]};
   assign trial   = rem_sh - {1'b0, dvs};
   assign qbit    = ~trial[XLEN];
   assign rem_nxt = qbit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_nxt = {dvd[XLEN-2:0], qbit};
   assign last    = (cnt == 6'(XLEN-1));
   assign fin     = ctx.is_rem ? (ctx.rneg ? -rem_nxt : rem_nxt)
                               : (ctx.qneg ? -quo_nxt : quo_nxt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.done  = 1'b0;
      bus.busy  = (state != IDLE);
      case (state)
         IDLE: if (bus.start) state_nxt = special ? DONE : CALC;
         CALC: if (last) state_nxt = DONE;
         DONE: begin
            state_nxt = IDLE;
            bus.done  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) begin
         state_nxt = IDLE;
         bus.done  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctx              <= '0;
         dvd              <= '0;
         dvs              <= '0;
         rem              <= '0;
         cnt              <= '0;
         bus.result       <= '0;
         bus.done_rd_addr <= '0;
      end else if (accept) begin
         ctx.is_rem <= bus.op[1];
         ctx.qneg   <= ~bus.op[1] & (s1 ^ s2);
         ctx.rneg   <= bus.op[1] & s1;
         ctx.rd     <= bus.rd_addr;
         dvd        <= abs1;
         dvs        <= abs2;
         rem        <= '0;
         cnt        <= '0;
         if (special) begin
            bus.result       <= spec_res;
            bus.done_rd_addr <= bus.rd_addr;
         end
      end else if (state == CALC && !bus.flush) begin
         dvd <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt + 6'd1;
         if (last) begin
            bus.result       <= fin;
            bus.done_rd_addr <= ctx.rd;
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv_divider.sv
// Self-checking bench for ex_muldiv_divider: vector table, scoreboard and corner sequences.
module tb_ex_muldiv_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;

   ex_muldiv_divider_if #(.XLEN(32)) bus();
   ex_muldiv_divider #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 result=%h expected no done at %0t", bus.result, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_result", bus.result, e.res);
            chk("sb_rd", 32'(bus.done_rd_addr), 32'(e.rd));
         end
      end
   end

   // Drive start in the current cycle; returns one cycle later (C+1).
   task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd);
      bus.start    = 1'b1;
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_addr  = rd;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat, input string nm, input logic [31:0] hres,
                            input logic [4:0] hrd, input bit hchk);
      int  n;
      bit  held;
      n    = 0;
      held = 1'b1;
      for (int i = 1; i <= 40 && n == 0; i++) begin
         @(negedge clk);
         if (i == 1) chk({nm, "_busy_c1"}, 32'(bus.busy), 32'd1);
         if (bus.done) n = i;
         else if (hchk && (bus.result !== hres || bus.done_rd_addr !== hrd)) held = 1'b0;
      end
      chk({nm, "_latency"}, n, lat);
      if (n != 0) begin
         chk({nm, "_busy_at_done"}, 32'(bus.busy), 32'd1);
         @(negedge clk);
         chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
      end
      if (hchk) chk({nm, "_held"}, 32'(held), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      sb_q.push_back('{v.exp, v.rd});
      drive_start(v.op, v.a, v.b, v.rd);
      wait_done(v.lat, nm, 32'h0, 5'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         33};
      vecs[1]  = '{2'b11, 32'd100,        32'd7,          5'd6,  32'd2,          33};
      vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFD,   33};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          5'd8,  32'hFFFFFFFF,   33};
      vecs[4]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   5'd9,  32'd1,          33};
      vecs[5]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   5'd10, 32'hFFFFFFFD,   33};
      vecs[6]  = '{2'b01, 32'h1234,       32'd0,          5'd11, 32'hFFFFFFFF,   1};
      vecs[7]  = '{2'b10, 32'h1234,       32'd0,          5'd12, 32'h1234,       1};
      vecs[8]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd13, 32'h80000000,   1};
      vecs[9]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd14, 32'd0,          1};
      vecs[10] = '{2'b00, 32'h80000000,   32'd2,          5'd15, 32'hC0000000,   33};
      vecs[11] = '{2'b01, 32'hFFFFFFFF,   32'd10,         5'd16, 32'h19999999,   33};
      vecs[12] = '{2'b11, 32'hFFFFFFFF,   32'd10,         5'd17, 32'd5,          33};
      vecs[13] = '{2'b00, 32'h80000000,   32'd3,          5'd18, 32'hD5555556,   33};
      vecs[14] = '{2'b01, 32'hFFFFFFFF,   32'd1,          5'd9,  32'hFFFFFFFF,   33};

      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
      bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_addr = '0;

      #3;
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_done",   32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd",     32'(bus.done_rd_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors issued back-to-back at the earliest accepted cycle.
      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Flush in cycle 10 of DIVU 100/7; new op in cycle 11 completes in cycle 44.
      drive_start(2'b01, 32'd100, 32'd7, 5'd3);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy",   32'(bus.busy), 32'd0);
      chk("flush_result", bus.result, 32'hFFFFFFFF);
      chk("flush_rd",     32'(bus.done_rd_addr), 32'd9);
      sb_q.push_back('{32'd10, 5'd12});
      drive_start(2'b01, 32'd50, 32'd5, 5'd12);
      wait_done(33, "flush_new", 32'hFFFFFFFF, 5'd9, 1'b1);

      // Start pulses in cycles 5 and 33 are ignored; start in cycle 34 is taken.
      sb_q.push_back('{32'd14, 5'd5});
      drive_start(2'b01, 32'd100, 32'd7, 5'd5);
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1; bus.rs1_data = 32'd1; bus.rs2_data = 32'd1; bus.rd_addr = 5'd1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (27) @(posedge clk);
      #1 bus.start = 1'b1;
      @(negedge clk);
      chk("busy_seq_done33", 32'(bus.done), 32'd1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("busy_seq_busy34", 32'(bus.busy), 32'd0);
      sb_q.push_back('{32'd3, 5'd7});
      drive_start(2'b01, 32'd9, 32'd3, 5'd7);
      wait_done(33, "busy_seq_next", 32'h0, 5'h0, 1'b0);

      // Asynchronous reset mid-cycle 20 discards the op immediately.
      sb_q.push_back('{32'd14, 5'd6});
      drive_start(2'b01, 32'd100, 32'd7, 5'd6);
      repeat (19) @(posedge clk);
      #2 rst = 1'b1;
      sb_q.delete();
      #1;
      chk("arst_busy",   32'(bus.busy), 32'd0);
      chk("arst_done",   32'(bus.done), 32'd0);
      chk("arst_result", bus.result, 32'd0);
      chk("arst_rd",     32'(bus.done_rd_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sb_q.push_back('{32'hFFFFFFFF, 5'd2});
      drive_start(2'b01, 32'hFFFFFFFF, 32'd1, 5'd2);
      wait_done(33, "post_rst", 32'h0, 5'h0, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
